bcd_mul3_gen: RTL and testbench
===============================

Name: bcd_mul3_gen

Overview:
Sequential source of BCD numbers for the divisible-by-3 checker. It is the producing end of the `bcd_stream` interface that the checker consumes. Starting from a loaded BCD seed, it emits seed, seed+3, seed+6, … over a valid/ready stream and stops at the last value that fits in DIGITS digits. It is used as a stimulus/workload generator feeding `divby3`-style consumers.

Parameters:
- DIGITS, 8, number of BCD digits in the stream (≥1). Digit 0 is the least significant, at bits [3:0].

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, level sampled in IDLE; loads `seed` and begins generation.
- stop, input, 1, abort; returns to IDLE from any state.
- seed, input, 4*DIGITS, BCD start value.
- bcd_stream, output, 4*DIGITS, current BCD value.
- out_valid, output, 1, `bcd_stream` holds a valid item.
- out_ready, input, 1, consumer accepts the item.
- done, output, 1, one-cycle pulse after the final item is accepted.
- seed_err, output, 1, one-cycle pulse when `seed` contains a digit greater than 9.
- busy, output, 1, high in RUN.
- residue, output, 2, `bcd_stream` mod 3 (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; bcd_stream=0; out_valid=0; done=0; seed_err=0; busy=0; residue=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1, all seed digits ≤9:
  - next cycle: RUN, bcd_stream=seed, out_valid=1.
  - Latency from start to first valid item is 1 cycle.
- IDLE, start=1, any seed digit >9:
  - stay in IDLE; seed_err=1 for one cycle; no item is emitted.
- RUN, transfer on out_valid & out_ready:
  - if bcd_stream+3 ≤ 10^DIGITS−1: bcd_stream ← BCD(bcd_stream+3) next cycle; out_valid stays 1.
  - otherwise (top-digit carry out): out_valid←0, state←DONE.
- RUN, out_valid & !out_ready: bcd_stream and out_valid hold stable. No item is skipped or duplicated.
- BCD add: per-digit ripple. Digit 0 adds 3; higher digits add the carry. A digit sum >9 subtracts 10 and sets the carry. The carry out of digit DIGITS−1 is the overflow flag.
- Boundary: 10^DIGITS−1 (all nines) is divisible by 3.
  - A seed that is a multiple of 3 ends exactly on all-nines.
  - Other seeds end on the largest value ≤ all-nines with the same residue.
- DONE: done=1 for exactly one cycle, then IDLE next cycle.
- stop=1 in RUN or DONE: IDLE next cycle, out_valid=0 immediately on that edge, done is not pulsed. An unaccepted item is dropped.
- stop and start together in IDLE: stop wins; nothing is loaded.
- start in RUN or DONE: ignored.
- seed is sampled only on the loading edge; later changes have no effect.
- Reset asserted mid-RUN: outputs return to reset values asynchronously. After release, the block waits in IDLE.

Optional Feature:
- Macro: BCD_MUL3_GEN_RESIDUE_EN.
- Defined:
  - `residue` = bcd_stream mod 3, valid whenever out_valid=1.
  - On load it is computed from the sum of the seed digits mod 3 (per-digit table, then a reduction tree).
  - It is held constant while stepping, since adding 3 preserves it.
  - It is an independent cross-check for the consumer.
- Not defined: `residue` is tied to 2'd0 and no residue logic is synthesised.

Decomposition:
- Package bcd_gen_pkg holds:
  - the state encoding (IDLE/RUN/DONE);
  - BCD_NINE = 4'd9;
  - STEP = 4'd3;
  - the digit-valid check function (digit ≤ 9).
- One sub-module, bcd_digit_add: 4-bit digit + 4-bit addend + carry_in → 4-bit digit + carry_out. It is instantiated DIGITS times in a generate loop.

Test Plan:
1. DIGITS=2, seed=0x00, start pulse, out_ready=1 → 34 items 0x00,0x03,…,0x99 on consecutive cycles; done pulses one cycle after 0x99 is accepted; residue=0 throughout if enabled.
2. DIGITS=2, seed=0x97, out_ready=1 → items 0x97 then 0x00 never appears; sequence is 0x97 only, then done (0x97+3 overflows); residue=1 if enabled.
3. Backpressure: seed=0x12, out_ready low for 5 cycles, then toggling 1/0 → bcd_stream stable at 0x12 while stalled; accepted sequence is 0x12,0x15,0x18,0x21 with no gaps or repeats.
4. Invalid seed: DIGITS=2, seed=0x1A, start → seed_err single pulse, out_valid stays 0, state remains IDLE; a following start with seed=0x09 emits 0x09.
5. Abort: seed=0x30, stop asserted after 0x36 is presented → out_valid=0 next edge, done never pulses; a new start with seed=0x00 restarts at 0x00.
6. Reset mid-run: rst_n low while out_valid=1 at 0x45 → outputs zero asynchronously (without waiting for a clock edge); after release, out_valid stays 0 until start.

Source files
------------

// File: rtl/bcd_mul3_gen_pkg.sv
// Shared types and helpers for the BCD multiple-of-three stream generator.
// Holds the FSM state encoding, BCD digit constants and digit helpers.
// Optional residue output is enabled with the BCD_MUL3_GEN_RESIDUE_EN macro.
package bcd_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] STEP     = 4'd3;

    // A nibble is a legal BCD digit when it does not exceed nine.
    function automatic logic digit_ok(input logic [3:0] d);
        return (d <= BCD_NINE);
    endfunction

    // Residue of a single legal BCD digit modulo three.
    function automatic logic [1:0] digit_mod3(input logic [3:0] d);
        logic [1:0] r;
        case (d)
            4'd0, 4'd3, 4'd6, 4'd9: r = 2'd0;
            4'd1, 4'd4, 4'd7:       r = 2'd1;
            default:                r = 2'd2;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bcd_mul3_gen_if.sv
// Stream bundle between a BCD generator and its controller/consumer.
// No latency of its own; carries the valid/ready item handshake.
// slave = generator side, master = controller/consumer side.
interface bcd_mul3_gen_if #(
    parameter int DIGITS = 8
);
    logic                  start;
    logic                  stop;
    logic [4*DIGITS-1:0]   seed;
    logic [4*DIGITS-1:0]   bcd_stream;
    logic                  out_valid;
    logic                  out_ready;
    logic                  done;
    logic                  seed_err;
    logic                  busy;
    logic [1:0]            residue;

    modport master (
        output start, stop, seed, out_ready,
        input  bcd_stream, out_valid, done, seed_err, busy, residue
    );

    modport slave (
        input  start, stop, seed, out_ready,
        output bcd_stream, out_valid, done, seed_err, busy, residue
    );
endinterface

// File: rtl/bcd_mul3_gen_digit_add.sv
// Single BCD digit adder: digit + addend + carry in, decimal-corrected.
// Purely combinational, zero latency.
// No handshake; used as one stage of a ripple chain.
module bcd_digit_add
    import bcd_gen_pkg::*;
(
    input  logic [3:0] i_dig,
    input  logic [3:0] i_add,
    input  logic       i_cin,
    output logic [3:0] o_dig,
    output logic       o_cout
);

    logic [4:0] w_sum;

    // Binary sum, then subtract ten and carry when it leaves the BCD range.
    always_comb begin
        w_sum = {1'b0, i_dig} + {1'b0, i_add} + {4'd0, i_cin};
        if (w_sum > {1'b0, BCD_NINE}) begin
            o_dig  = w_sum[3:0] - 4'd10;
            o_cout = 1'b1;
        end else begin
            o_dig  = w_sum[3:0];
            o_cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_mul3_gen.sv
// Emits seed, seed+3, seed+6, ... in BCD until the next step would overflow DIGITS digits.
// First item one cycle after start; each accepted item advances in one cycle.
// Item held stable while out_ready is low; stop drops any pending item. Macro: BCD_MUL3_GEN_RESIDUE_EN.
module bcd_mul3_gen
    import bcd_gen_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_mul3_gen_if.slave         bus
);

    state_t                r_state;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_valid;
    logic                  r_done;
    logic                  r_err;
    logic                  r_busy;

    logic [4*DIGITS-1:0]   w_next;
    logic [DIGITS:0]       w_cin;
    logic                  w_seed_ok;

    assign w_cin[0] = 1'b0;

    // Ripple chain: digit 0 adds the step, higher digits only absorb the carry.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        localparam logic [3:0] ADDEND = (g == 0) ? STEP : 4'd0;
        bcd_digit_add u_add (
            .i_dig  (r_bcd[4*g +: 4]),
            .i_add  (ADDEND),
            .i_cin  (w_cin[g]),
            .o_dig  (w_next[4*g +: 4]),
            .o_cout (w_cin[g+1])
        );
    end

    // Seed is only loadable when every nibble is a legal BCD digit.
    always_comb begin
        w_seed_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!digit_ok(bus.seed[4*i +: 4])) w_seed_ok = 1'b0;
        end
    end

`ifdef BCD_MUL3_GEN_RESIDUE_EN
    logic [1:0] r_res;
    logic [1:0] w_seed_res;
    logic [2:0] w_acc;

    // Seed residue: per-digit mod-3 table folded digit by digit, staying in 0..2.
    always_comb begin
        w_seed_res = 2'd0;
        w_acc      = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_acc      = {1'b0, w_seed_res} + {1'b0, digit_mod3(bus.seed[4*i +: 4])};
            w_seed_res = (w_acc >= 3'd3) ? 2'(w_acc - 3'd3) : w_acc[1:0];
        end
    end

    assign bus.residue = r_res;
`else
    assign bus.residue = 2'd0;
`endif

    // Control FSM with all outputs registered; stop overrides every other request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_bcd   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
`ifdef BCD_MUL3_GEN_RESIDUE_EN
            r_res   <= 2'd0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!bus.stop && bus.start) begin
                        if (w_seed_ok) begin
                            r_state <= ST_RUN;
                            r_bcd   <= bus.seed;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
`ifdef BCD_MUL3_GEN_RESIDUE_EN
                            r_res   <= w_seed_res;
`endif
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_valid && bus.out_ready) begin
                        if (w_cin[DIGITS]) begin
                            // Next step would not fit: the accepted item was the last one.
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_bcd <= w_next;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.bcd_stream = r_bcd;
    assign bus.out_valid  = r_valid;
    assign bus.done       = r_done;
    assign bus.seed_err   = r_err;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_bcd_mul3_gen.sv
// Testbench for bcd_mul3_gen at DIGITS=2 against an integer reference of seed+3k.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Residue expectations follow BCD_MUL3_GEN_RESIDUE_EN when defined.
module tb_bcd_mul3_gen;

    localparam int D    = 2;
    localparam int MAXV = 99;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    bcd_mul3_gen_if #(.DIGITS(D)) bus ();

    bcd_mul3_gen #(.DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal integer to two-digit packed BCD.
    function automatic logic [7:0] to_bcd(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [1:0] exp_res(input int v);
`ifdef BCD_MUL3_GEN_RESIDUE_EN
        return 2'(v % 3);
`else
        return 2'(v * 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Runs one full generation from sd; mode 0 ready=1, 1 random ready, 2 stall 5 then toggle.
    task automatic run_seq(input int sd, input int mode);
        int   exp_v;
        logic fin;
        logic rdy;
        bus.seed      = to_bcd(sd);
        bus.start     = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        bus.seed  = 8'($urandom);
        exp_v = sd;
        fin   = 1'b0;
        for (int i = 0; i < 400 && !fin; i++) begin
            chk("item_valid", 32'(bus.out_valid), 1);
            chk("item_value", 32'(bus.bcd_stream), 32'(to_bcd(exp_v)));
            chk("busy_run", 32'(bus.busy), 1);
            chk("residue", 32'(bus.residue), 32'(exp_res(exp_v)));
            chk("no_early_done", 32'(bus.done), 0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (i < 5) ? 1'b0 : 1'(i % 2);
            endcase
            bus.out_ready = rdy;
            tick();
            if (rdy) begin
                if (exp_v + 3 > MAXV) fin = 1'b1;
                else exp_v += 3;
            end
        end
        bus.out_ready = 1'b0;
        chk("seq_finished", 32'(fin), 1);
        chk("done_pulse", 32'(bus.done), 1);
        chk("valid_off", 32'(bus.out_valid), 0);
        chk("busy_off", 32'(bus.busy), 0);
        tick();
        chk("done_clear", 32'(bus.done), 0);
        chk("idle_valid", 32'(bus.out_valid), 0);
    endtask

    initial begin
        n_chk         = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.seed      = '0;
        bus.out_ready = 1'b0;
        repeat (2) tick();

        // Reset state.
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_stream", 32'(bus.bcd_stream), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_seed_err", 32'(bus.seed_err), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_residue", 32'(bus.residue), 0);
        rst_n = 1'b1;
        tick();

        // Full run from zero to all nines; then a seed that overflows on its first step.
        run_seq(0, 0);
        run_seq(97, 0);

        // Backpressure from 12.
        run_seq(12, 2);

        // Invalid seed, then a legal one.
        bus.seed  = 8'h1A;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("seed_err_pulse", 32'(bus.seed_err), 1);
        chk("seed_err_novalid", 32'(bus.out_valid), 0);
        tick();
        chk("seed_err_clear", 32'(bus.seed_err), 0);
        chk("seed_err_idle", 32'(bus.out_valid), 0);
        run_seq(9, 0);

        // Stop and start together in IDLE: nothing loads.
        bus.seed  = to_bcd(3);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("stop_wins_valid", 32'(bus.out_valid), 0);
        chk("stop_wins_busy", 32'(bus.busy), 0);

        // Abort after 36 is presented.
        bus.seed  = to_bcd(30);
        bus.start = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        chk("abort_at36", 32'(bus.bcd_stream), 32'(to_bcd(36)));
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("abort_valid", 32'(bus.out_valid), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_nodone", 32'(bus.done), 0);
        tick();
        chk("abort_nodone2", 32'(bus.done), 0);
        run_seq(0, 1);

        // Reset asserted mid-run at 45, checked before any clock edge.
        bus.seed  = to_bcd(42);
        bus.start = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("pre_reset_45", 32'(bus.bcd_stream), 32'(to_bcd(45)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 0);
        chk("async_rst_stream", 32'(bus.bcd_stream), 0);
        chk("async_rst_busy", 32'(bus.busy), 0);
        chk("async_rst_residue", 32'(bus.residue), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", 32'(bus.out_valid), 0);

        // Random seeds with random backpressure.
        for (int k = 0; k < 6; k++) begin
            run_seq(int'($urandom_range(0, MAXV)), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
